reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 37 +++
 rtl/reservation_station_free_select.sv | 22 ++
 rtl/reservation_station.sv | 86 ++++++++
 tb/tb_reservation_station.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared system definitions for the reservation station: sizing, dispatch packet and CDB tags.
// Latency: n/a (types only). Backpressure: n/a.
package reservation_station_pkg;

  localparam int RS      = 4;
  localparam int PR      = 6;
  localparam int RS_SIZE = 2 ** RS;

  typedef struct packed {
    logic          valid;
    logic [31:0]   NPC;
    logic [31:0]   inst;
    logic [PR-1:0] dest_pr;
    logic [PR-1:0] reg1_pr;
    logic          reg1_ready;
    logic [PR-1:0] reg2_pr;
    logic          reg2_ready;
  } RS_IN_PACKET;

  typedef struct packed {
    logic          valid;
    logic [PR-1:0] pr;
  } CDB_TAG;

  typedef struct packed {
    CDB_TAG [2:0] t;
  } CDB_T_PACKET;

  // True when any valid broadcast tag names the given physical register.
  function automatic logic cdb_hit(input CDB_T_PACKET cdb, input logic [PR-1:0] pr);
    cdb_hit = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (cdb.t[t].valid && (cdb.t[t].pr == pr)) cdb_hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/reservation_station_free_select.sv
// Picks the three lowest-indexed free entries as one-hot grants, grant[0] lowest.
// Latency: combinational. Backpressure: none; a grant is all-zero when too few entries are free.
module reservation_station_free_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]      free_mask,
  output logic [2:0][N-1:0] grant
);

  logic [N-1:0] remaining;

  // Isolate the lowest set bit, then strip it before the next pick.
  always_comb begin
    remaining = free_mask;
    grant     = '0;
    for (int g = 0; g < 3; g++) begin
      grant[g]  = remaining & (-remaining);
      remaining = remaining & ~grant[g];
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: allocates up to three dispatched instructions per cycle and wakes operands from the CDB.
// Latency: one cycle write to display. Backpressure: struct_stall from free count, youngest slots stalled first.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  RS_IN_PACKET [2:0]         rs_in,
  input  CDB_T_PACKET               cdb_t,
  output logic [2:0]                struct_stall,
  output RS_IN_PACKET [RS_SIZE-1:0] rs_entries_display
);

  RS_IN_PACKET [RS_SIZE-1:0]  entries;
  RS_IN_PACKET [RS_SIZE-1:0]  entries_nxt;
  RS_IN_PACKET [2:0]          rs_in_bp;
  logic [RS_SIZE-1:0]         free_mask;
  logic [2:0][RS_SIZE-1:0]    grant;
  logic [2:0][RS_SIZE-1:0]    slot_sel;
  logic [RS:0]                free_cnt;
  logic [2:0]                 accept;

  always_comb begin
    free_cnt  = '0;
    free_mask = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_mask[i] = ~entries[i].valid;
      free_cnt     = free_cnt + {{RS{1'b0}}, free_mask[i]};
    end
  end

  always_comb begin
    case (free_cnt)
      (RS+1)'(0): struct_stall = 3'b111;
      (RS+1)'(1): struct_stall = 3'b011;
      (RS+1)'(2): struct_stall = 3'b001;
      default:    struct_stall = 3'b000;
    endcase
  end

  assign accept = {rs_in[2].valid, rs_in[1].valid, rs_in[0].valid} & ~struct_stall;

  reservation_station_free_select #(
    .N(RS_SIZE)
  ) u_free_select (
    .free_mask (free_mask),
    .grant     (grant)
  );

  // Older slots take lower entries; a skipped slot does not consume a grant.
  always_comb begin
    slot_sel    = '0;
    slot_sel[2] = accept[2] ? grant[0] : '0;
    slot_sel[1] = accept[1] ? grant[{1'b0, accept[2]}] : '0;
    slot_sel[0] = accept[0] ? grant[{1'b0, accept[2]} + {1'b0, accept[1]}] : '0;
  end

  always_comb begin
    rs_in_bp = rs_in;
    for (int k = 0; k < 3; k++) begin
      rs_in_bp[k].reg1_ready = rs_in[k].reg1_ready | cdb_hit(cdb_t, rs_in[k].reg1_pr);
      rs_in_bp[k].reg2_ready = rs_in[k].reg2_ready | cdb_hit(cdb_t, rs_in[k].reg2_pr);
    end
  end

  always_comb begin
    entries_nxt = entries;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (entries[i].valid) begin
        if (cdb_hit(cdb_t, entries[i].reg1_pr)) entries_nxt[i].reg1_ready = 1'b1;
        if (cdb_hit(cdb_t, entries[i].reg2_pr)) entries_nxt[i].reg2_ready = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (slot_sel[k][i]) entries_nxt[i] = rs_in_bp[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) entries <= '0;
    else       entries <= entries_nxt;
  end

  assign rs_entries_display = entries;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed steps plus random dispatch/CDB traffic against an
// append-only list model of the entry array.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                      clock;
  logic                      reset;
  RS_IN_PACKET [2:0]         rs_in;
  CDB_T_PACKET               cdb_t;
  logic [2:0]                struct_stall;
  RS_IN_PACKET [RS_SIZE-1:0] rs_entries_display;

  int compared;
  int mismatched;

  RS_IN_PACKET m [RS_SIZE];
  int          used;

  reservation_station dut (
    .clock              (clock),
    .reset              (reset),
    .rs_in              (rs_in),
    .cdb_t              (cdb_t),
    .struct_stall       (struct_stall),
    .rs_entries_display (rs_entries_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_stall();
    int f;
    f = RS_SIZE - used;
    if (f >= 3)      return 3'b000;
    else if (f == 2) return 3'b001;
    else if (f == 1) return 3'b011;
    else             return 3'b111;
  endfunction

  function automatic logic tag_match(input logic [PR-1:0] pr);
    for (int t = 0; t < 3; t++)
      if (cdb_t.t[t].valid && cdb_t.t[t].pr == pr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < RS_SIZE; i++) m[i] = '0;
    used = 0;
  endtask

  // Accepted slots append to the list oldest first; then every held entry sees the broadcast.
  task automatic model_edge();
    logic [2:0] st;
    st = exp_stall();
    for (int k = 2; k >= 0; k--) begin
      if (rs_in[k].valid && !st[k]) begin
        m[used] = rs_in[k];
        used++;
      end
    end
    for (int i = 0; i < used; i++) begin
      if (tag_match(m[i].reg1_pr)) m[i].reg1_ready = 1'b1;
      if (tag_match(m[i].reg2_pr)) m[i].reg2_ready = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < RS_SIZE; i++)
      chk($sformatf("entry%0d", i), 128'(rs_entries_display[i]), 128'(m[i]));
  endtask

  task automatic step();
    chk("stall_pre", 128'(struct_stall), 128'(exp_stall()));
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("stall_reset", 128'(struct_stall), 128'(3'b000));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic RS_IN_PACKET rand_pkt(input logic vld);
    RS_IN_PACKET p;
    p.valid      = vld;
    p.NPC        = $urandom;
    p.inst       = $urandom;
    p.dest_pr    = PR'($urandom_range(0, 63));
    p.reg1_pr    = PR'($urandom_range(0, 7));
    p.reg1_ready = ($urandom_range(0, 3) == 0);
    p.reg2_pr    = PR'($urandom_range(0, 7));
    p.reg2_ready = ($urandom_range(0, 3) == 0);
    return p;
  endfunction

  task automatic rand_cdb();
    for (int t = 0; t < 3; t++) begin
      cdb_t.t[t].valid = $urandom_range(0, 1) == 1;
      cdb_t.t[t].pr    = PR'($urandom_range(0, 7));
    end
  endtask

  function automatic RS_IN_PACKET mk(input logic [31:0] npc, input logic [31:0] inst,
                                     input int r1, input int r2);
    RS_IN_PACKET p;
    p            = '0;
    p.valid      = 1'b1;
    p.NPC        = npc;
    p.inst       = inst;
    p.dest_pr    = PR'(npc[5:0] + 6'd20);
    p.reg1_pr    = PR'(r1);
    p.reg2_pr    = PR'(r2);
    return p;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rs_in      = '0;
    cdb_t      = '0;
    model_clear();
    do_reset();

    // Three-wide dispatch into an empty station.
    rs_in[2] = mk(32'd4,  32'h40418133, 1, 2);
    rs_in[1] = mk(32'd8,  32'h00208033, 1, 2);
    rs_in[0] = mk(32'd12, 32'h007302b3, 3, 4);
    step();
    chk("e0_npc", 128'(rs_entries_display[0].NPC), 128'(32'd4));
    chk("e1_npc", 128'(rs_entries_display[1].NPC), 128'(32'd8));
    chk("e2_npc", 128'(rs_entries_display[2].NPC), 128'(32'd12));
    chk("e2_valid", 128'(rs_entries_display[2].valid), 128'(1'b1));
    chk("stall_3used", 128'(struct_stall), 128'(3'b000));

    // Invalid oldest slot consumes nothing.
    rs_in[2].valid = 1'b0;
    step();
    chk("e3_npc", 128'(rs_entries_display[3].NPC), 128'(32'd8));
    chk("e4_npc", 128'(rs_entries_display[4].NPC), 128'(32'd12));
    chk("e5_valid", 128'(rs_entries_display[5].valid), 128'(1'b0));

    // Fill to the limit.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt(1'b1);
      rand_cdb();
      step();
    end
    chk("stall_15used", 128'(struct_stall), 128'(3'b011));
    for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt(1'b1);
    cdb_t = '0;
    step();
    chk("e15_npc", 128'(rs_entries_display[15].NPC), 128'(rs_in[2].NPC));
    chk("stall_full", 128'(struct_stall), 128'(3'b111));
    for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt(1'b1);
    step();

    // Wakeup: invalid tag ignored, valid tag sets ready; then same-cycle bypass.
    do_reset();
    rs_in    = '0;
    rs_in[2] = mk(32'h100, 32'h00500093, 5, 3);
    step();
    for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt(1'b0);
    cdb_t         = '0;
    cdb_t.t[1].pr = PR'(5);
    step();
    chk("r1_rdy_badtag", 128'(rs_entries_display[0].reg1_ready), 128'(1'b0));
    cdb_t.t[1].valid = 1'b1;
    step();
    chk("r1_rdy_wake", 128'(rs_entries_display[0].reg1_ready), 128'(1'b1));
    chk("r2_rdy_nowake", 128'(rs_entries_display[0].reg2_ready), 128'(1'b0));
    cdb_t    = '0;
    cdb_t.t[0] = '{valid: 1'b1, pr: PR'(9)};
    rs_in    = '0;
    rs_in[1] = mk(32'h104, 32'h00900113, 12, 9);
    step();
    chk("r2_rdy_bypass", 128'(rs_entries_display[1].reg2_ready), 128'(1'b1));
    chk("r1_rdy_nobyp", 128'(rs_entries_display[1].reg1_ready), 128'(1'b0));

    // Asynchronous reset mid-cycle, held across an edge with valid inputs.
    rs_in = '0;
    cdb_t = '0;
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("stall_async", 128'(struct_stall), 128'(3'b000));
    for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt(1'b1);
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;

    // Random traffic until and beyond full.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int c = 0; c < 14; c++) begin
        for (int k = 0; k < 3; k++) rs_in[k] = rand_pkt($urandom_range(0, 9) < 7);
        rand_cdb();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
